// File: rtl/spi_rx_sipo.sv
// SPI receive SIPO: assembles LARGO-bit words from MISO on the ena strobe
// and hands them out through a single-entry valid/ready output register.
// Ports: clk, rst (async, active low), start/stop (frame pulses),
//   ena/DatIn (bit strobe, serial data), ready (consumer accept),
//   ovr_clr (clear flags), DatOut/valid (word out), busy (in SHIFT),
//   ovr (sticky overrun), err (sticky truncated frame).
// Option: define SPI_RX_LSB_FIRST_EN for LSB-first bit order.

module spi_rx_sipo #(
  parameter int LARGO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             ena,
  input  logic             DatIn,
  input  logic             ready,
  input  logic             ovr_clr,
  output logic [LARGO-1:0] DatOut,
  output logic             valid,
  output logic             busy,
  output logic             ovr,
  output logic             err
);

  localparam int CW = $clog2(LARGO);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [LARGO-2:0] sreg;
  logic [LARGO-2:0] sreg_nxt;
  logic [LARGO-2:0] shifted;
  logic [LARGO-1:0] word;
  logic             last;
  logic             done;
  logic             trunc;
  logic             drop;

  // word is the full value if this sample completes it; the shifted
  // register is the same concatenation minus the oldest slot.
`ifdef SPI_RX_LSB_FIRST_EN
  assign word    = {DatIn, sreg};
  assign shifted = word[LARGO-1:1];
`else
  assign word    = {sreg, DatIn};
  assign shifted = word[LARGO-2:0];
`endif

  assign last = (cnt == CW'(LARGO - 1));
  assign busy = (state == SHIFT);
  assign drop = done & valid & ~ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sreg  <= sreg_nxt;
    end
  end

  // start beats stop beats ena; a stop still lets a completing bit land.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    done      = 1'b0;
    trunc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          cnt_nxt = '0;
          trunc   = (cnt != '0);
        end else if (stop) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (ena && last) begin
            done = 1'b1;
          end else begin
            trunc = (cnt != '0);
          end
        end else if (ena) begin
          if (last) begin
            done    = 1'b1;
            cnt_nxt = '0;
          end else begin
            sreg_nxt = shifted;
            cnt_nxt  = cnt + CW'(1);
          end
        end
      end
    endcase
  end

  // A completing word may replace one being consumed on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DatOut <= '0;
      valid  <= 1'b0;
    end else if (done) begin
      if (!valid || ready) begin
        DatOut <= word;
        valid  <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr <= 1'b0;
      err <= 1'b0;
    end else begin
      ovr <= drop | (ovr & ~ovr_clr);
      err <= trunc | (err & ~ovr_clr);
    end
  end

endmodule

// File: tb/tb_spi_rx_sipo.sv
// Randomized bench for spi_rx_sipo against a queue-based frame model.
// Directed scenarios first, then a random traffic phase.

module tb_spi_rx_sipo;

  localparam int L = 8;

  logic         clk = 0;
  logic         rst = 0;
  logic         start = 0;
  logic         stop = 0;
  logic         ena = 0;
  logic         din = 0;
  logic         ready = 0;
  logic         ovr_clr = 0;
  logic [L-1:0] dout;
  logic         valid;
  logic         busy;
  logic         ovr;
  logic         err;

  int checks = 0;
  int failures = 0;

  bit           m_fr;
  bit           q[$];
  logic [L-1:0] m_dout;
  bit           m_valid;
  bit           m_ovr;
  bit           m_err;

  spi_rx_sipo #(.LARGO(L)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .ena    (ena),
    .DatIn  (din),
    .ready  (ready),
    .ovr_clr(ovr_clr),
    .DatOut (dout),
    .valid  (valid),
    .busy   (busy),
    .ovr    (ovr),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [L-1:0] pack();
    logic [L-1:0] w = '0;
    for (int i = 0; i < L; i++) begin
`ifdef SPI_RX_LSB_FIRST_EN
      w[i] = q[i];
`else
      w = {w[L-2:0], q[i]};
`endif
    end
    return w;
  endfunction

  task automatic m_reset();
    m_fr = 0;
    q.delete();
    m_dout = '0;
    m_valid = 0;
    m_ovr = 0;
    m_err = 0;
  endtask

  task automatic model_edge();
    bit done = 0;
    bit tr = 0;
    bit dr = 0;
    logic [L-1:0] w = '0;
    if (!m_fr) begin
      if (start) begin
        m_fr = 1;
        q.delete();
      end
    end else if (start) begin
      tr = (q.size() != 0);
      q.delete();
    end else if (stop) begin
      m_fr = 0;
      if (ena && q.size() == L - 1) begin
        q.push_back(din);
        done = 1;
        w = pack();
      end else begin
        tr = (q.size() != 0);
      end
      q.delete();
    end else if (ena) begin
      q.push_back(din);
      if (q.size() == L) begin
        done = 1;
        w = pack();
        q.delete();
      end
    end
    if (done) begin
      if (!m_valid || ready) begin
        m_dout = w;
        m_valid = 1;
      end else begin
        dr = 1;
      end
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
    m_ovr = dr | (m_ovr & !ovr_clr);
    m_err = tr | (m_err & !ovr_clr);
  endtask

  task automatic cmp();
    chk("dout", 32'(dout), 32'(m_dout));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_fr));
    chk("ovr", 32'(ovr), 32'(m_ovr));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic cyc(bit s, bit p, bit e, bit d, bit r, bit c);
    start = s;
    stop = p;
    ena = e;
    din = d;
    ready = r;
    ovr_clr = c;
    @(posedge clk);
    model_edge();
    #1;
    cmp();
  endtask

  task automatic send_word(logic [L-1:0] w, bit r, bit r_last);
    for (int i = 0; i < L; i++) begin
`ifdef SPI_RX_LSB_FIRST_EN
      cyc(0, 0, 1, w[i], (i == L - 1) ? r_last : r, 0);
`else
      cyc(0, 0, 1, w[L-1-i], (i == L - 1) ? r_last : r, 0);
`endif
    end
  endtask

  initial begin
    logic [L-1:0] raw;
    m_reset();
    #12;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({ovr, err}), 0);
    rst = 1;

    // single word
    cyc(1, 0, 0, 0, 1, 0);
    send_word(8'hA5, 1, 1);
    chk("t1_dout", 32'(dout), 32'h A5);
    chk("t1_valid", 32'(valid), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t1_valid_drop", 32'(valid), 0);
    chk("t1_dout_hold", 32'(dout), 32'hA5);

    // overrun
    send_word(8'h3C, 0, 0);
    send_word(8'hC3, 0, 0);
    chk("t2_dout", 32'(dout), 32'h3C);
    chk("t2_ovr", 32'(ovr), 1);
    chk("t2_valid", 32'(valid), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t2_ovr_clr", 32'(ovr), 0);

    // accept on completion edge
    cyc(0, 0, 0, 0, 1, 0);
    send_word(8'h11, 0, 0);
    send_word(8'h22, 0, 1);
    chk("t3_dout", 32'(dout), 32'h22);
    chk("t3_valid", 32'(valid), 1);
    chk("t3_ovr", 32'(ovr), 0);
    cyc(0, 1, 0, 0, 1, 0);
    chk("t3_stop_err", 32'(err), 0);

    // truncated frame
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("t4_err", 32'(err), 1);
    chk("t4_valid", 32'(valid), 0);
    chk("t4_busy", 32'(busy), 0);
    cyc(1, 0, 0, 0, 0, 0);
    send_word(8'hFF, 0, 0);
    chk("t4_dout", 32'(dout), 32'hFF);
    cyc(0, 0, 0, 0, 1, 1);
    chk("t4_err_clr", 32'(err), 0);

    // async reset mid-frame
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    #2 rst = 0;
    #1;
    m_reset();
    chk("t5_dout", 32'(dout), 0);
    chk("t5_busy", 32'(busy), 0);
    #2 rst = 1;
    cyc(1, 0, 0, 0, 0, 0);
    send_word(8'h81, 0, 0);
    chk("t5_word", 32'(dout), 32'h81);
    cyc(0, 1, 0, 0, 1, 0);

    // stop coinciding with last bit still delivers the word
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < L - 1; i++) cyc(0, 0, 1, i[0], 0, 0);
    cyc(0, 1, 1, 1, 0, 0);
    chk("t6_valid", 32'(valid), 1);
    chk("t6_err", 32'(err), 0);
    chk("t6_busy", 32'(busy), 0);
    cyc(0, 0, 0, 0, 1, 0);

    // raw bit order: 1 then seven zeros
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < L; i++) cyc(0, 0, 1, (i == 0), 0, 0);
`ifdef SPI_RX_LSB_FIRST_EN
    raw = 8'h01;
`else
    raw = 8'h80;
`endif
    chk("t7_order", 32'(dout), 32'(raw));
    cyc(0, 1, 0, 0, 1, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 60, 1'($urandom),
          $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
